// File: rtl/nbody_pkg.sv
// Shared constants and the run-state encoding for the n-body timestep scheduler.
package nbody_pkg;
    localparam int BODIES      = 512;
    localparam int IDX_W       = $clog2(BODIES);
    localparam int ACC_LAT_DEF = 123;
    localparam int ADD_LAT_DEF = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_ACC_DRAIN,
        S_POS,
        S_POS_DRAIN,
        S_DONE
    } state_t;
endpackage

// File: rtl/nbody_step_sched_tag_delay.sv
// Fixed-depth shift line carrying a valid bit plus a tag; clr drops every in-flight valid.
module tag_delay #(
    parameter int STAGES = 1,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              pend
);
    logic [STAGES-1:0] vld_p;
    logic [DATA_W-1:0] data_p [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            for (int k = 0; k < STAGES; k++) data_p[k] <= '0;
        end else begin
            vld_p[0]  <= in_vld & ~clr;
            data_p[0] <= in_data;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k]  <= vld_p[k-1] & ~clr;
                data_p[k] <= data_p[k-1];
            end
        end
    end

    assign out_vld  = vld_p[STAGES-1];
    assign out_data = data_p[STAGES-1];

    // pend covers entries still in flight, excluding the one being presented
    generate
        if (STAGES > 1) begin : g_pend
            assign pend = |vld_p[STAGES-2:0];
        end else begin : g_nopend
            assign pend = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/nbody_step_sched.sv
// Sequences all-pairs acceleration issue and position write-back for S timesteps over N bodies.
module nbody_step_sched
    import nbody_pkg::*;
#(
    parameter int BODIES  = nbody_pkg::BODIES,
    parameter int IDX_W   = $clog2(BODIES),
    parameter int ACC_LAT = nbody_pkg::ACC_LAT_DEF,
    parameter int ADD_LAT = nbody_pkg::ADD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             done_ack,
    input  logic [IDX_W:0]   num_bodies,
    input  logic [15:0]      num_steps,
    output logic             busy,
    output logic             done,
    output logic             pair_valid,
    output logic [IDX_W-1:0] pair_i,
    output logic [IDX_W-1:0] pair_j,
    output logic             acc_valid,
    output logic [IDX_W-1:0] acc_i,
    output logic             acc_last,
    output logic             pos_rd_valid,
    output logic [IDX_W-1:0] pos_rd_addr,
    output logic             pos_wr_valid,
    output logic [IDX_W-1:0] pos_wr_addr,
    output logic             first_step,
    output logic [15:0]      step_cnt
);
    state_t         state, state_nxt;
    logic [IDX_W:0] n_lat;
    logic [15:0]    s_lat;
    logic           clr;
    logic           acc_pend, acc_any, wr_pend, wr_final;
    logic [IDX_W:0] acc_tag;
    logic [IDX_W:0] n_m1, pi_x, pj_x, j_final_x, j_inc_x, j_nxt_x, n_next;
    logic           pair_last, pair_final, pos_last, run_empty, start_ok;

    // Pair-walk arithmetic runs one bit wider so N == BODIES compares cleanly
    assign n_m1       = n_lat - 1'b1;
    assign pi_x       = {1'b0, pair_i};
    assign pj_x       = {1'b0, pair_j};
    assign j_final_x  = (pi_x == n_m1) ? n_m1 - 1'b1 : n_m1;
    assign pair_last  = (pj_x == j_final_x);
    assign pair_final = pair_last && (pi_x == n_m1);
    assign j_inc_x    = pj_x + 1'b1;
    assign j_nxt_x    = (j_inc_x == pi_x) ? j_inc_x + 1'b1 : j_inc_x;
    assign pos_last   = ({1'b0, pos_rd_addr} == n_m1);
    assign run_empty  = (num_bodies == '0) || (num_steps == '0);
    assign start_ok   = start && (state == S_IDLE);
    assign n_next     = (state == S_IDLE) ? num_bodies : n_lat;
    assign acc_any    = acc_pend | acc_valid;
    assign wr_final   = pos_wr_valid && !wr_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        clr          = 1'b0;
        busy         = (state != S_IDLE);
        pair_valid   = (state == S_ACCEL) && (n_lat > (IDX_W+1)'(1));
        pos_rd_valid = (state == S_POS);
        case (state)
            S_IDLE:      if (start) state_nxt = run_empty ? S_DONE : S_ACCEL;
            S_ACCEL:     if (!pair_valid || pair_final) state_nxt = S_ACC_DRAIN;
            S_ACC_DRAIN: if (!acc_any) state_nxt = S_POS;
            S_POS:       if (pos_last) state_nxt = S_POS_DRAIN;
            S_POS_DRAIN: if (wr_final) state_nxt = (step_cnt + 16'd1 == s_lat) ? S_DONE : S_ACCEL;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            clr       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_lat       <= '0;
            s_lat       <= '0;
            step_cnt    <= '0;
            first_step  <= 1'b0;
            done        <= 1'b0;
            pair_i      <= '0;
            pair_j      <= '0;
            pos_rd_addr <= '0;
        end else begin
            if (start_ok) begin
                n_lat      <= num_bodies;
                s_lat      <= num_steps;
                step_cnt   <= '0;
                first_step <= !run_empty;
            end
            if (state_nxt == S_DONE && state != S_DONE) done <= 1'b1;
            else if (done_ack || start_ok)               done <= 1'b0;
            // First pair of each step is (0,1); a lone body parks j at 0
            if (state_nxt == S_ACCEL && state != S_ACCEL) begin
                pair_i <= '0;
                pair_j <= (n_next > (IDX_W+1)'(1)) ? IDX_W'(1) : '0;
            end else if (pair_valid && !pair_final) begin
                if (pair_last) begin
                    pair_i <= pair_i + IDX_W'(1);
                    pair_j <= '0;
                end else begin
                    pair_j <= j_nxt_x[IDX_W-1:0];
                end
            end
            if (state_nxt == S_POS && state != S_POS) pos_rd_addr <= '0;
            else if (pos_rd_valid && !pos_last)       pos_rd_addr <= pos_rd_addr + IDX_W'(1);
            if (state == S_POS_DRAIN && wr_final && !clr) begin
                step_cnt   <= step_cnt + 16'd1;
                first_step <= 1'b0;
            end
            if (clr) first_step <= 1'b0;
        end
    end

    tag_delay #(.STAGES(ACC_LAT), .DATA_W(IDX_W + 1)) u_acc_line (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_vld   (pair_valid),
        .in_data  ({pair_i, pair_last}),
        .out_vld  (acc_valid),
        .out_data (acc_tag),
        .pend     (acc_pend)
    );
    assign acc_i    = acc_tag[IDX_W:1];
    assign acc_last = acc_tag[0];

    // One cycle of RAM read latency ahead of the adder
    tag_delay #(.STAGES(ADD_LAT + 1), .DATA_W(IDX_W)) u_pos_line (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_vld   (pos_rd_valid),
        .in_data  (pos_rd_addr),
        .out_vld  (pos_wr_valid),
        .out_data (pos_wr_addr),
        .pend     (wr_pend)
    );
endmodule

// File: tb/tb_nbody_step_sched.sv
// Scoreboard bench for nbody_step_sched: expected strobe streams are queued per run and popped as the DUT emits them.
module tb_nbody_step_sched;
    localparam int BODIES  = 64;
    localparam int IDX_W   = 6;
    localparam int ACC_LAT = 4;
    localparam int ADD_LAT = 2;

    logic             clk = 1'b0;
    logic             rst, start, abort, done_ack;
    logic [IDX_W:0]   num_bodies;
    logic [15:0]      num_steps;
    logic             busy, done, pair_valid, acc_valid, acc_last;
    logic             pos_rd_valid, pos_wr_valid, first_step;
    logic [IDX_W-1:0] pair_i, pair_j, acc_i, pos_rd_addr, pos_wr_addr;
    logic [15:0]      step_cnt;

    nbody_step_sched #(.BODIES(BODIES), .IDX_W(IDX_W), .ACC_LAT(ACC_LAT), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .done_ack(done_ack),
        .num_bodies(num_bodies), .num_steps(num_steps), .busy(busy), .done(done),
        .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j),
        .acc_valid(acc_valid), .acc_i(acc_i), .acc_last(acc_last),
        .pos_rd_valid(pos_rd_valid), .pos_rd_addr(pos_rd_addr),
        .pos_wr_valid(pos_wr_valid), .pos_wr_addr(pos_wr_addr),
        .first_step(first_step), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int i; int j; bit last; } pair_t;
    typedef struct { int cyc; int i; bit last; } acc_t;
    typedef struct { int addr; bit first; } rd_t;
    typedef struct { int cyc; int addr; } wr_t;

    pair_t exp_pairs[$];
    acc_t  exp_acc[$];
    rd_t   exp_rd[$];
    wr_t   exp_wr[$];

    int total = 0, bad = 0, cyc = 0;
    int npair = 0, nlast = 0, nacc = 0, max_idx = 0;
    int first_pair_cyc = -1, last_pair_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (pair_valid) begin
                pair_t pe;
                npair++;
                if (first_pair_cyc < 0) first_pair_cyc = cyc;
                last_pair_cyc = cyc;
                if (int'(pair_i) > max_idx) max_idx = int'(pair_i);
                if (int'(pair_j) > max_idx) max_idx = int'(pair_j);
                total++;
                if (exp_pairs.size() == 0) begin
                    bad++;
                    $display("FAIL pair_extra got (%0d,%0d) want none", pair_i, pair_j);
                end else begin
                    pe = exp_pairs.pop_front();
                    if (pair_i !== IDX_W'(pe.i) || pair_j !== IDX_W'(pe.j)) begin
                        bad++;
                        $display("FAIL pair got (%0d,%0d) want (%0d,%0d)", pair_i, pair_j, pe.i, pe.j);
                    end
                    exp_acc.push_back('{cyc: cyc + ACC_LAT, i: pe.i, last: pe.last});
                end
            end
            if (acc_valid) begin
                acc_t ae;
                nacc++;
                if (acc_last) nlast++;
                if (int'(acc_i) > max_idx) max_idx = int'(acc_i);
                total++;
                if (exp_acc.size() == 0) begin
                    bad++;
                    $display("FAIL acc_extra got i=%0d at cyc %0d want none", acc_i, cyc);
                end else begin
                    ae = exp_acc.pop_front();
                    if (cyc != ae.cyc || acc_i !== IDX_W'(ae.i) || acc_last !== ae.last) begin
                        bad++;
                        $display("FAIL acc got cyc=%0d i=%0d last=%0b want cyc=%0d i=%0d last=%0b",
                                 cyc, acc_i, acc_last, ae.cyc, ae.i, ae.last);
                    end
                end
            end
            if (pos_rd_valid) begin
                rd_t re;
                if (int'(pos_rd_addr) > max_idx) max_idx = int'(pos_rd_addr);
                total++;
                if (exp_rd.size() == 0) begin
                    bad++;
                    $display("FAIL rd_extra got addr=%0d want none", pos_rd_addr);
                end else begin
                    re = exp_rd.pop_front();
                    if (pos_rd_addr !== IDX_W'(re.addr) || first_step !== re.first) begin
                        bad++;
                        $display("FAIL rd got addr=%0d first=%0b want addr=%0d first=%0b",
                                 pos_rd_addr, first_step, re.addr, re.first);
                    end
                    exp_wr.push_back('{cyc: cyc + ADD_LAT + 1, addr: re.addr});
                end
            end
            if (pos_wr_valid) begin
                wr_t we;
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL wr_extra got addr=%0d want none", pos_wr_addr);
                end else begin
                    we = exp_wr.pop_front();
                    if (cyc != we.cyc || pos_wr_addr !== IDX_W'(we.addr)) begin
                        bad++;
                        $display("FAIL wr got cyc=%0d addr=%0d want cyc=%0d addr=%0d",
                                 cyc, pos_wr_addr, we.cyc, we.addr);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_model(input int n, input int s);
        for (int st = 0; st < s; st++) begin
            if (n >= 2) begin
                for (int i = 0; i < n; i++) begin
                    for (int j = 0; j < n; j++)
                        if (j != i) exp_pairs.push_back('{i: i, j: j, last: 1'b0});
                    exp_pairs[exp_pairs.size() - 1].last = 1'b1;
                end
            end
            for (int a = 0; a < n; a++) exp_rd.push_back('{addr: a, first: (st == 0)});
        end
    endtask

    task automatic clear_stats();
        npair = 0; nlast = 0; nacc = 0; max_idx = 0;
        first_pair_cyc = -1; last_pair_cyc = -1;
    endtask

    task automatic pulse_start(input int n, input int s, input bit ack);
        @(posedge clk); #1;
        start = 1'b1; num_bodies = (IDX_W+1)'(n); num_steps = 16'(s); done_ack = ack;
        @(posedge clk); #1;
        start = 1'b0; done_ack = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout done=%b want 1 after %0d cycles", tag, done, budget);
        end
        total++;
        if (exp_pairs.size() + exp_acc.size() + exp_rd.size() + exp_wr.size() != 0) begin
            bad++;
            $display("FAIL %s_leftover pairs=%0d acc=%0d rd=%0d wr=%0d want 0", tag,
                     exp_pairs.size(), exp_acc.size(), exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic ack_done(input string tag);
        @(posedge clk); #1; done_ack = 1'b1;
        @(posedge clk); #1; done_ack = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_ack done=%b busy=%b want 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; done_ack = 1'b0;
        num_bodies = '0; num_steps = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, first_step, pair_valid, acc_valid, pos_rd_valid, pos_wr_valid} !== 7'b0 ||
            step_cnt !== 16'd0 || pair_i !== '0 || pair_j !== '0 || pos_rd_addr !== '0 ||
            acc_i !== '0 || pos_wr_addr !== '0) begin
            bad++;
            $display("FAIL reset busy=%b done=%b fs=%b pv=%b av=%b rv=%b wv=%b step=%0d i=%0d j=%0d want all 0",
                     busy, done, first_step, pair_valid, acc_valid, pos_rd_valid, pos_wr_valid,
                     step_cnt, pair_i, pair_j);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        clear_stats();
        push_model(3, 1);
        pulse_start(3, 1, 1'b0);
        total++;
        if (busy !== 1'b1 || first_step !== 1'b1 || step_cnt !== 16'd0) begin
            bad++;
            $display("FAIL basic_start busy=%b fs=%b step=%0d want 1 1 0", busy, first_step, step_cnt);
        end
        wait_done("basic", 500);
        total++;
        if (step_cnt !== 16'd1 || npair != 6 || nlast != 3 || last_pair_cyc - first_pair_cyc != 5) begin
            bad++;
            $display("FAIL basic_counts step=%0d pairs=%0d lasts=%0d span=%0d want 1 6 3 5",
                     step_cnt, npair, nlast, last_pair_cyc - first_pair_cyc);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b1 || first_step !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle busy=%b done=%b fs=%b want 0 1 0", busy, done, first_step);
        end
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL idle_abort busy=%b done=%b want 0 1", busy, done);
        end
        ack_done("basic");
    endtask

    task automatic test_single();
        clear_stats();
        push_model(1, 2);
        pulse_start(1, 2, 1'b0);
        wait_done("single", 500);
        total++;
        if (step_cnt !== 16'd2 || npair != 0 || nacc != 0 || first_step !== 1'b0) begin
            bad++;
            $display("FAIL single step=%0d pairs=%0d accs=%0d fs=%b want 2 0 0 0",
                     step_cnt, npair, nacc, first_step);
        end
        ack_done("single");
    endtask

    task automatic test_empty();
        int ns [2] = '{0, 2};
        int ss [2] = '{3, 0};
        for (int t = 0; t < 2; t++) begin
            clear_stats();
            pulse_start(ns[t], ss[t], 1'b0);
            total++;
            if (done !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL empty%0d_done done=%b busy=%b want 1 1", t, done, busy);
            end
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b1 || step_cnt !== 16'd0 || npair != 0) begin
                bad++;
                $display("FAIL empty%0d_idle busy=%b done=%b step=%0d pairs=%0d want 0 1 0 0",
                         t, busy, done, step_cnt, npair);
            end
            ack_done("empty");
        end
    endtask

    task automatic test_abort();
        int k = 0;
        clear_stats();
        push_model(4, 1);
        pulse_start(4, 1, 1'b0);
        while (npair < 12 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (npair != 12 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup pairs=%0d busy=%b want 12 1", npair, busy);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_acc.delete(); exp_rd.delete(); exp_wr.delete(); exp_pairs.delete();
        nacc = 0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle busy=%b want 0", busy);
        end
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (nacc != 0 || done !== 1'b0 || first_step !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet accs=%0d done=%b fs=%b want 0 0 0", nacc, done, first_step);
        end
        clear_stats();
        push_model(2, 1);
        pulse_start(2, 1, 1'b0);
        wait_done("abort_rerun", 500);
        total++;
        if (step_cnt !== 16'd1 || npair != 2 || nlast != 2) begin
            bad++;
            $display("FAIL abort_rerun step=%0d pairs=%0d lasts=%0d want 1 2 2", step_cnt, npair, nlast);
        end
        ack_done("abort");
    endtask

    task automatic test_back_to_back();
        clear_stats();
        push_model(3, 1);
        pulse_start(3, 1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        pulse_start(2, 5, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_busy busy=%b want 1", busy);
        end
        wait_done("b2b_first", 500);
        total++;
        if (step_cnt !== 16'd1 || npair != 6) begin
            bad++;
            $display("FAIL b2b_first step=%0d pairs=%0d want 1 6", step_cnt, npair);
        end
        @(posedge clk); #1;
        clear_stats();
        push_model(2, 2);
        pulse_start(2, 2, 1'b1);
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || step_cnt !== 16'd0) begin
            bad++;
            $display("FAIL b2b_restart done=%b busy=%b step=%0d want 0 1 0", done, busy, step_cnt);
        end
        wait_done("b2b_second", 500);
        total++;
        if (step_cnt !== 16'd2 || npair != 4) begin
            bad++;
            $display("FAIL b2b_second step=%0d pairs=%0d want 2 4", step_cnt, npair);
        end
        ack_done("b2b");
    endtask

    task automatic test_full();
        clear_stats();
        push_model(BODIES, 1);
        pulse_start(BODIES, 1, 1'b0);
        wait_done("full", 10000);
        total++;
        if (npair != BODIES * (BODIES - 1) || nlast != BODIES || max_idx > BODIES - 1 || step_cnt !== 16'd1) begin
            bad++;
            $display("FAIL full pairs=%0d lasts=%0d max=%0d step=%0d want %0d %0d <=%0d 1",
                     npair, nlast, max_idx, step_cnt, BODIES * (BODIES - 1), BODIES, BODIES - 1);
        end
        ack_done("full");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_empty();
        test_abort();
        test_back_to_back();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
